// File: rtl/shift_request_queue.sv
// Request FIFO and registered output slot in front of an external combinational barrel shifter.
// Optional same-cycle bypass of an empty FIFO is enabled by defining SHIFT_QUEUE_BYPASS_EN.
module shift_request_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [N-1:0]               In_Data,
    input  logic [$clog2(N)-1:0]       In_Shift_Val,
    input  logic                       In_Left_Right,
    input  logic                       In_Logic_Arithmetic,
    output logic [N-1:0]               Sh_Input,
    output logic [$clog2(N)-1:0]       Sh_Shift_Val,
    output logic                       Sh_Left_Right,
    output logic                       Sh_Logic_Arithmetic,
    input  logic [N-1:0]               Sh_Result,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [N-1:0]               Out_Result,
    output logic [$clog2(DEPTH+1)-1:0] Out_Count
);
    localparam int SW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = N + SW + 2;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          out_valid_reg;
    logic [N-1:0]  out_result_reg;

    logic [EW-1:0] in_entry, head_entry, sh_entry;
    logic          fifo_empty, slot_free, push, pop, bypass, fifo_write, capture;

    assign in_entry   = {In_Data, In_Shift_Val, In_Left_Right, In_Logic_Arithmetic};
    assign head_entry = mem[rd_ptr_reg];

    assign fifo_empty = (count_reg == '0);
    assign In_Ready   = (count_reg != CW'(DEPTH));
    assign slot_free  = !out_valid_reg || Out_Ready;
    assign push       = In_Valid && In_Ready;
    assign pop        = !fifo_empty && slot_free;

`ifdef SHIFT_QUEUE_BYPASS_EN
    // An empty FIFO lets the incoming request go straight to the shifter.
    assign bypass     = fifo_empty && In_Valid && slot_free;
`else
    assign bypass     = 1'b0;
`endif

    assign fifo_write = push && !bypass;
    assign capture    = pop || bypass;

    always_comb begin
        sh_entry = '0;
        if (!fifo_empty)
            sh_entry = head_entry;
        else if (bypass)
            sh_entry = in_entry;
    end

    assign {Sh_Input, Sh_Shift_Val, Sh_Left_Right, Sh_Logic_Arithmetic} = sh_entry;

    always_comb begin
        count_next = count_reg;
        case ({fifo_write, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge Clock) begin
        if (fifo_write)
            mem[wr_ptr_reg] <= in_entry;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (fifo_write)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (capture) begin
                out_valid_reg  <= 1'b1;
                out_result_reg <= Sh_Result;
            end else if (Out_Ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign Out_Valid  = out_valid_reg;
    assign Out_Result = out_result_reg;
    assign Out_Count  = count_reg;
endmodule

// File: tb/tb_shift_request_queue.sv
// Directed self-checking bench for shift_request_queue; models the external barrel shifter.
module tb_shift_request_queue;
    localparam int N     = 32;
    localparam int DEPTH = 4;
`ifdef SHIFT_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        Clock, Reset_n;
    logic        In_Valid, In_Ready;
    logic [31:0] In_Data;
    logic [4:0]  In_Shift_Val;
    logic        In_Left_Right, In_Logic_Arithmetic;
    logic [31:0] Sh_Input;
    logic [4:0]  Sh_Shift_Val;
    logic        Sh_Left_Right, Sh_Logic_Arithmetic;
    logic [31:0] Sh_Result;
    logic        Out_Valid, Out_Ready;
    logic [31:0] Out_Result;
    logic [2:0]  Out_Count;

    int checks   = 0;
    int failures = 0;

    shift_request_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
        .In_Shift_Val(In_Shift_Val), .In_Left_Right(In_Left_Right),
        .In_Logic_Arithmetic(In_Logic_Arithmetic),
        .Sh_Input(Sh_Input), .Sh_Shift_Val(Sh_Shift_Val), .Sh_Left_Right(Sh_Left_Right),
        .Sh_Logic_Arithmetic(Sh_Logic_Arithmetic), .Sh_Result(Sh_Result),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Result(Out_Result),
        .Out_Count(Out_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural stand-in for the downstream barrel shifter.
    always_comb begin
        if (!Sh_Left_Right)
            Sh_Result = Sh_Input << Sh_Shift_Val;
        else if (Sh_Logic_Arithmetic)
            Sh_Result = $unsigned($signed(Sh_Input) >>> Sh_Shift_Val);
        else
            Sh_Result = Sh_Input >> Sh_Shift_Val;
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                         input logic lr, input logic la);
        In_Valid = v; In_Data = d; In_Shift_Val = s;
        In_Left_Right = lr; In_Logic_Arithmetic = la;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Out_Ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", Out_Valid); end
        checks++; if (Out_Count !== 3'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", Out_Count); end
        checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", In_Ready); end
        checks++; if (Out_Result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", Out_Result); end
        checks++; if (Sh_Input !== 32'h0) begin failures++; $display("FAIL reset_sh_input got=%h exp=0", Sh_Input); end
        $display("test_reset done");
        Reset_n = 1'b1;
    endtask

    task automatic test_single_shifts;
        logic [31:0] td[4], te[4];
        logic [4:0]  ts[4];
        logic        tl[4], ta[4];
        td = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        ts = '{5'd4, 5'd31, 5'd31, 5'd4};
        tl = '{1'b0, 1'b1, 1'b1, 1'b1};
        ta = '{1'b0, 1'b1, 1'b0, 1'b1};
        te = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0400_0000};
        for (int v = 0; v < 4; v++) begin
            @(negedge Clock);
            Out_Ready = 1'b0;
            drive(1'b1, td[v], ts[v], tl[v], ta[v]);
            checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL shift%0d_in_ready got=%0b exp=1", v, In_Ready); end
            @(negedge Clock);
            In_Valid = 1'b0;
            checks++; if (Out_Valid !== BYPASS) begin failures++; $display("FAIL shift%0d_latency got=%0b exp=%0b", v, Out_Valid, BYPASS); end
            checks++; if (Out_Count !== (BYPASS ? 3'd0 : 3'd1)) begin failures++; $display("FAIL shift%0d_count got=%0d", v, Out_Count); end
            @(negedge Clock);
            checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL shift%0d_valid got=%0b exp=1", v, Out_Valid); end
            checks++; if (Out_Result !== te[v]) begin failures++; $display("FAIL shift%0d_result got=%h exp=%h", v, Out_Result, te[v]); end
            Out_Ready = 1'b1;
            @(negedge Clock);
            checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL shift%0d_drain got=%0b exp=0", v, Out_Valid); end
            Out_Ready = 1'b0;
            $display("test_single_shifts vec=%0d data=%h sh=%0d lr=%0b la=%0b result=%h exp=%h",
                     v, td[v], ts[v], tl[v], ta[v], Out_Result, te[v]);
        end
    endtask

    task automatic test_backpressure;
        int acc;
        acc = 0;
        Out_Ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            drive(1'b1, 32'(k + 1), 5'd1, 1'b0, 1'b0);
            if (In_Ready === 1'b1) acc++;
        end
        @(negedge Clock);
        In_Valid = 1'b0;
        checks++; if (acc !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
        checks++; if (Out_Count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", Out_Count); end
        checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", In_Ready); end
        checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", Out_Valid); end
        checks++; if (Out_Result !== 32'd2) begin failures++; $display("FAIL bp_held got=%h exp=2", Out_Result); end
        $display("test_backpressure accepted=%0d count=%0d held=%h", acc, Out_Count, Out_Result);
        Out_Ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge Clock);
            checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL bp_drain%0d_valid got=%0b exp=1", k, Out_Valid); end
            checks++; if (Out_Result !== 32'(k * 2)) begin failures++; $display("FAIL bp_drain%0d_result got=%h exp=%h", k, Out_Result, k * 2); end
            if (k == 2) begin
                checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL bp_resume got=%0b exp=1", In_Ready); end
            end
            $display("test_backpressure drain req=%0d result=%h", k, Out_Result);
        end
        @(negedge Clock);
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%0b exp=0", Out_Valid); end
        checks++; if (Out_Count !== 3'd0) begin failures++; $display("FAIL bp_empty_count got=%0d exp=0", Out_Count); end
    endtask

    task automatic test_pointer_wrap;
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int          got;
        logic [2:0]  max_count;
        max_count = BYPASS ? 3'd0 : 3'd1;
        got = 0;
        Out_Ready = 1'b1;
        for (int c = 0; c < 3 * DEPTH + 4; c++) begin
            @(negedge Clock);
            if (Out_Valid === 1'b1) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++; if (Out_Result !== e) begin failures++; $display("FAIL wrap_result%0d got=%h exp=%h", got, Out_Result, e); end
                $display("test_pointer_wrap result=%0d value=%h exp=%h", got, Out_Result, e);
            end
            checks++; if (Out_Count > max_count) begin failures++; $display("FAIL wrap_count got=%0d max=%0d", Out_Count, max_count); end
            if (c < 3 * DEPTH) begin
                drive(1'b1, 32'(c), 5'(c % 32), 1'b0, 1'b0);
                checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL wrap_in_ready%0d got=%0b exp=1", c, In_Ready); end
                exp_q.push_back(32'(c) << (c % 32));
            end else begin
                In_Valid = 1'b0;
            end
        end
        checks++; if (got !== 3 * DEPTH) begin failures++; $display("FAIL wrap_total got=%0d exp=%0d", got, 3 * DEPTH); end
    endtask

    task automatic test_reset_mid;
        Out_Ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            drive(1'b1, 32'h11 + 32'(k), 5'd1, 1'b0, 1'b0);
        end
        @(negedge Clock);
        In_Valid = 1'b0;
        checks++; if (Out_Count !== 3'd3) begin failures++; $display("FAIL rst_pre_count got=%0d exp=3", Out_Count); end
        checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%0b exp=1", Out_Valid); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", Out_Valid); end
        checks++; if (Out_Count !== 3'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", Out_Count); end
        checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%0b exp=1", In_Ready); end
        #1 Reset_n = 1'b1;
        $display("test_reset_mid async reset applied valid=%0b count=%0d", Out_Valid, Out_Count);
        @(negedge Clock);
        drive(1'b1, 32'h0000_00F0, 5'd4, 1'b1, 1'b0);
        @(negedge Clock);
        In_Valid = 1'b0;
        checks++; if (Out_Valid !== BYPASS) begin failures++; $display("FAIL rst_new_latency got=%0b exp=%0b", Out_Valid, BYPASS); end
        checks++; if (Out_Result !== (BYPASS ? 32'h0000_000F : 32'h0)) begin failures++; $display("FAIL rst_stale got=%h", Out_Result); end
        @(negedge Clock);
        checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL rst_new_valid got=%0b exp=1", Out_Valid); end
        checks++; if (Out_Result !== 32'h0000_000F) begin failures++; $display("FAIL rst_new_result got=%h exp=0000000f", Out_Result); end
        checks++; if (Out_Count !== 3'd0) begin failures++; $display("FAIL rst_new_count got=%0d exp=0", Out_Count); end
        $display("test_reset_mid new result=%h", Out_Result);
        Out_Ready = 1'b1;
        repeat (2) begin
            @(negedge Clock);
            checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_no_stale got=%0b exp=0", Out_Valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_shifts();
        test_backpressure();
        test_pointer_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
